ifu: RTL and testbench



---
 rtl/ifu_pkg.sv | 41 ++++
 rtl/ifu_if.sv | 43 ++++
 rtl/ifu_fifo.sv | 97 +++++++++
 rtl/ifu.sv | 131 +++++++++++++
 tb/tb_ifu.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ifu_pkg                                                      |
// | Description : Shared types and constants for the instruction fetch unit:  |
// |               bus widths, NOP / zero-word encodings, queue entry layout    |
// |               and a word-alignment helper.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ifu_pkg;

   localparam int c_inst_w = 32;
   localparam int c_addr_w = 32;

   typedef logic [c_inst_w-1:0] inst_t;
   typedef logic [c_addr_w-1:0] addr_t;

   localparam addr_t c_zero_word = '0;
   localparam inst_t c_inst_nop  = 32'h0000_0013;   // addi x0, x0, 0

   // Level constants for entry flags
   localparam logic c_set   = 1'b1;
   localparam logic c_clear = 1'b0;

   localparam int c_ifu_fifo_depth = 4;

   // One queue slot: fetch address, returned instruction, data-present flag
   typedef struct packed {
      addr_t addr;
      inst_t inst;
      logic  filled;
   } ifu_entry_t;

   // Force an address onto a 32-bit word boundary
   function automatic addr_t align_word(input addr_t a);
      return {a[c_addr_w-1:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ifu_if                                                       |
// | Description : Bundle of every non-clock signal around the fetch unit.     |
// |   ibus_req_valid/ready/addr : fetch request channel (ifu -> bus)           |
// |   ibus_rsp_valid/data       : in-order fetch response (bus -> ifu)         |
// |   redirect/redirect_addr    : taken branch / jump from ex                  |
// |   ready                     : decode can accept                            |
// |   valid/inst/instaddr       : instruction presented to if_id               |
// |   Modport master = ifu side, slave = bus + ex + decode side.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface ifu_if;
   import ifu_pkg::*;

   logic  ibus_req_valid;
   logic  ibus_req_ready;
   addr_t ibus_req_addr;
   logic  ibus_rsp_valid;
   inst_t ibus_rsp_data;
   logic  redirect;
   addr_t redirect_addr;
   logic  ready;
   logic  valid;
   inst_t inst;
   addr_t instaddr;

   modport master (
      output ibus_req_valid, ibus_req_addr, valid, inst, instaddr,
      input  ibus_req_ready, ibus_rsp_valid, ibus_rsp_data,
             redirect, redirect_addr, ready
   );

   modport slave (
      input  ibus_req_valid, ibus_req_addr, valid, inst, instaddr,
      output ibus_req_ready, ibus_rsp_valid, ibus_rsp_data,
             redirect, redirect_addr, ready
   );

endinterface

`default_nettype wire

// File: rtl/ifu_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ifu_fifo                                                     |
// | Description : Address-tagged instruction queue with three pointers:       |
// |               wr (allocate on request), fill (in-order response) and      |
// |               rd (pop to decode). Pointers carry one extra wrap bit.      |
// |   clk, rstn           : clock, async active-low reset                      |
// |   flush               : drop every entry, pointers to zero                 |
// |   alloc, alloc_addr   : reserve slot at wr for a newly issued fetch        |
// |   fill, fill_data     : write response into slot at fill                   |
// |   pop                 : release slot at rd                                 |
// |   count, unfilled     : wr-rd and wr-fill                                  |
// |   head_*              : contents of slot at rd                             |
// |   head_at_fill        : head is the slot that the next response fills      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = c_ifu_fifo_depth
)(
   input  wire logic                   clk,
   input  wire logic                   rstn,
   input  wire logic                   flush,
   input  wire logic                   alloc,
   input  wire addr_t                  alloc_addr,
   input  wire logic                   fill,
   input  wire inst_t                  fill_data,
   input  wire logic                   pop,
   output logic [$clog2(DEPTH):0]      count,
   output logic [$clog2(DEPTH):0]      unfilled,
   output logic                        head_filled,
   output addr_t                       head_addr,
   output inst_t                       head_inst,
   output logic                        head_at_fill
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_fill;
   logic [PW-1:0] r_rd;
   ifu_entry_t    r_q [DEPTH];
   logic          w_fill_write;

   assign count        = r_wr - r_rd;
   assign unfilled     = r_wr - r_fill;
   assign head_at_fill = (r_rd == r_fill) && (count != '0);
   assign head_filled  = r_q[r_rd[IW-1:0]].filled;
   assign head_addr    = r_q[r_rd[IW-1:0]].addr;
   assign head_inst    = r_q[r_rd[IW-1:0]].inst;

   // A fill that pops in the same cycle went straight to decode; the slot is
   // released, so writing it would only leave a stale filled flag behind.
   assign w_fill_write = fill && !(pop && head_at_fill);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr   <= '0;
         r_fill <= '0;
         r_rd   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q[i] <= '0;
         end
      end else if (flush) begin
         r_wr   <= '0;
         r_fill <= '0;
         r_rd   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q[i].filled <= c_clear;
         end
      end else begin
         // alloc and fill never target the same slot: that would need the
         // queue full (no alloc) or nothing outstanding (no legal fill).
         if (alloc) begin
            r_q[r_wr[IW-1:0]].addr   <= alloc_addr;
            r_q[r_wr[IW-1:0]].filled <= c_clear;
            r_wr                     <= r_wr + PW'(1);
         end
         if (fill) begin
            if (w_fill_write) begin
               r_q[r_fill[IW-1:0]].inst   <= fill_data;
               r_q[r_fill[IW-1:0]].filled <= c_set;
            end
            r_fill <= r_fill + PW'(1);
         end
         if (pop) begin
            r_rd <= r_rd + PW'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ifu.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ifu                                                          |
// | Description : Instruction fetch unit. Holds the PC, issues in-order word  |
// |               fetches, queues tagged responses and hands one instruction  |
// |               per cycle to decode. A redirect flushes wrong-path state;   |
// |               responses still in flight are counted and discarded.        |
// |   clk, rstn : clock, asynchronous active-low reset                         |
// |   ifc       : ifu_if.master (instruction bus, redirect, decode handshake)  |
// |   Build option IFU_BYPASS_EN: a response that lands on the empty head     |
// |   slot is presented to decode in the same cycle.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ifu
   import ifu_pkg::*;
#(
   parameter int    FIFO_DEPTH = c_ifu_fifo_depth,
   parameter addr_t RESET_PC   = 32'h0000_0000
)(
   input  wire logic clk,
   input  wire logic rstn,
   ifu_if.master     ifc
);

   localparam int PW = $clog2(FIFO_DEPTH) + 1;
   // Headroom for stale responses piling up across back-to-back redirects
   localparam int DW = PW + 4;

   addr_t         r_pc;
   logic [DW-1:0] r_drop_cnt;

   logic [PW-1:0] w_count;
   logic [PW-1:0] w_unfilled;
   logic          w_head_filled;
   addr_t         w_head_addr;
   inst_t         w_head_inst;
   logic          w_head_at_fill;

   logic          w_full;
   logic          w_req_valid;
   logic          w_req_fire;
   logic          w_rsp_drop;
   logic          w_rsp_live;
   logic          w_fill;
   logic          w_head_valid;
   logic          w_bypass;
   logic          w_valid;
   logic          w_pop;

   // ---------------- request issue ----------------
   assign w_full      = (w_count == PW'(FIFO_DEPTH));
   // rstn gating keeps the request low while reset is held
   assign w_req_valid = rstn && !w_full && !ifc.redirect;
   assign w_req_fire  = w_req_valid && ifc.ibus_req_ready;

   assign ifc.ibus_req_valid = w_req_valid;
   assign ifc.ibus_req_addr  = r_pc;

   // ---------------- response path ----------------
   assign w_rsp_drop = ifc.ibus_rsp_valid && (r_drop_cnt != '0);
   assign w_rsp_live = ifc.ibus_rsp_valid && (r_drop_cnt == '0);
   assign w_fill     = w_rsp_live && !ifc.redirect;

   // ---------------- decode side ----------------
   assign w_head_valid = w_head_filled && (w_count != '0) && !ifc.redirect;

`ifdef IFU_BYPASS_EN
   assign w_bypass = w_head_at_fill && w_rsp_live && !ifc.redirect;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_valid = w_head_valid || w_bypass;
   assign w_pop   = w_valid && ifc.ready;

   assign ifc.valid    = w_valid;
   assign ifc.inst     = !w_valid ? c_inst_nop  :
                         w_bypass ? ifc.ibus_rsp_data : w_head_inst;
   assign ifc.instaddr = w_valid  ? w_head_addr : c_zero_word;

   // ---------------- PC and stale-response counter ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc       <= RESET_PC;
         r_drop_cnt <= '0;
      end else if (ifc.redirect) begin
         r_pc <= align_word(ifc.redirect_addr);
         // Every allocated-but-unfilled slot still has a response coming.
         // A response arriving now is swallowed by the flush either way.
         r_drop_cnt <= r_drop_cnt + DW'(w_unfilled) - DW'(ifc.ibus_rsp_valid);
      end else begin
         if (w_req_fire) begin
            r_pc <= r_pc + 32'd4;
         end
         if (w_rsp_drop) begin
            r_drop_cnt <= r_drop_cnt - DW'(1);
         end
      end
   end

   ifu_fifo #(
      .DEPTH        (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rstn         (rstn),
      .flush        (ifc.redirect),
      .alloc        (w_req_fire),
      .alloc_addr   (r_pc),
      .fill         (w_fill),
      .fill_data    (ifc.ibus_rsp_data),
      .pop          (w_pop),
      .count        (w_count),
      .unfilled     (w_unfilled),
      .head_filled  (w_head_filled),
      .head_addr    (w_head_addr),
      .head_inst    (w_head_inst),
      .head_at_fill (w_head_at_fill)
   );

   // A response must belong to an outstanding fetch: live or stale
   a_rsp_expected: assert property (@(posedge clk) disable iff (!rstn)
      ifc.ibus_rsp_valid |-> ((r_drop_cnt != '0) || (w_unfilled != '0)));

   // Only the bypass may pop a slot that has not received its data
   a_pop_filled: assert property (@(posedge clk) disable iff (!rstn)
      (w_pop && w_head_at_fill) |-> w_bypass);

endmodule

`default_nettype wire

// File: tb/tb_ifu.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ifu                                                       |
// | Description : Directed bench for ifu. A small in-order bus responder with |
// |               programmable latency returns data = addr ^ A500_0000; a     |
// |               decode-side monitor checks the delivered address stream.    |
// |               Expected timing follows IFU_BYPASS_EN when defined.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ifu;
   import ifu_pkg::*;

`ifdef IFU_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk;
   logic rstn;
   ifu_if ifc ();

   ifu #(
      .FIFO_DEPTH (4),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .ifc  (ifc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        q[$];
   int          cyc;
   int          lat;
   bit          bus_auto;
   bit          mon_en;
   logic [31:0] exp_addr;
   int          pops;
   int          first_pop;
   int          n_acc;
   int          n_checks;
   int          n_pass;

   function automatic logic [31:0] rsp_word(input logic [31:0] a);
      return a ^ 32'hA500_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One clock: sample handshakes at negedge, then advance and drive the bus
   task automatic cycle();
      @(negedge clk);
      if (ifc.ibus_req_valid && ifc.ibus_req_ready) begin
         n_acc++;
         if (bus_auto) q.push_back('{addr: ifc.ibus_req_addr, due: cyc + lat});
      end
      if (mon_en && ifc.valid && ifc.ready) begin
         check("pop_addr", ifc.instaddr, exp_addr);
         check("pop_inst", ifc.inst, rsp_word(exp_addr));
         exp_addr = exp_addr + 32'd4;
         pops++;
         if (first_pop < 0) first_pop = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
      ifc.ibus_rsp_valid = 1'b0;
      if (bus_auto && q.size() > 0 && q[0].due <= cyc) begin
         ifc.ibus_rsp_valid = 1'b1;
         ifc.ibus_rsp_data  = rsp_word(q[0].addr);
         void'(q.pop_front());
      end
   endtask

   // Asserted away from the clock edge, so reset values must appear at once
   task automatic do_reset();
      rstn               = 1'b0;
      q.delete();
      ifc.ibus_rsp_valid = 1'b0;
      ifc.ibus_rsp_data  = '0;
      ifc.redirect       = 1'b0;
      ifc.redirect_addr  = '0;
      ifc.ready          = 1'b1;
      ifc.ibus_req_ready = 1'b1;
      bus_auto           = 1'b1;
      mon_en             = 1'b1;
      #1;
      check("rst_req_valid", {31'd0, ifc.ibus_req_valid}, 32'd0);
      check("rst_req_addr",  ifc.ibus_req_addr, 32'h0000_0000);
      check("rst_valid",     {31'd0, ifc.valid}, 32'd0);
      check("rst_inst",      ifc.inst, 32'h0000_0013);
      check("rst_instaddr",  ifc.instaddr, 32'h0000_0000);
      repeat (2) @(posedge clk);
      #1;
      rstn      = 1'b1;
      cyc       = 0;
      pops      = 0;
      first_pop = -1;
      exp_addr  = 32'h0;
      n_acc     = 0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      lat      = 1;
      #2;

      // ---- streaming, always-ready bus, 1-cycle response ----
      do_reset();
      #2;
      check("t1_req_valid", {31'd0, ifc.ibus_req_valid}, 32'd1);
      check("t1_req_addr0", ifc.ibus_req_addr, 32'h0);
      check("t1_valid0",    {31'd0, ifc.valid}, 32'd0);
      cycle();
      #2;
      check("t1_req_addr1", ifc.ibus_req_addr, 32'h4);
      repeat (11) cycle();
      check("t1_first_pop", first_pop, BYP ? 32'd1 : 32'd2);
      check("t1_pops",      pops,      BYP ? 32'd11 : 32'd10);

      // ---- decode stalled: queue fills, then drains in order ----
      do_reset();
      ifc.ready = 1'b0;
      repeat (10) cycle();
      #2;
      check("t2_accepts",   n_acc, 32'd4);
      check("t2_req_valid", {31'd0, ifc.ibus_req_valid}, 32'd0);
      check("t2_valid",     {31'd0, ifc.valid}, 32'd1);
      check("t2_head_addr", ifc.instaddr, 32'h0);
      ifc.ready = 1'b1;
      repeat (8) cycle();
      check("t2_pops", pops, 32'd8);

      // ---- bus not ready: address held, pc frozen ----
      do_reset();
      repeat (4) cycle();
      ifc.ibus_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         check("t3_hold_addr",  ifc.ibus_req_addr, 32'h10);
         check("t3_hold_valid", {31'd0, ifc.ibus_req_valid}, 32'd1);
         cycle();
      end
      ifc.ibus_req_ready = 1'b1;
      #2;
      check("t3_accept_addr", ifc.ibus_req_addr, 32'h10);
      cycle();
      #2;
      check("t3_next_addr", ifc.ibus_req_addr, 32'h14);
      check("t3_accepts",   n_acc, 32'd5);
      repeat (6) cycle();
      check("t3_pops", pops, BYP ? 32'd10 : 32'd9);

      // ---- redirect with two fetches outstanding (3-cycle latency) ----
      lat = 3;
      do_reset();
      repeat (2) cycle();
      ifc.redirect      = 1'b1;
      ifc.redirect_addr = 32'h0000_0103;
      #2;
      check("t4_redir_req_valid", {31'd0, ifc.ibus_req_valid}, 32'd0);
      check("t4_redir_valid",     {31'd0, ifc.valid}, 32'd0);
      exp_addr  = 32'h100;
      first_pop = -1;
      cycle();
      ifc.redirect = 1'b0;
      #2;
      check("t4_new_addr", ifc.ibus_req_addr, 32'h100);
      check("t4_drop0",    {31'd0, ifc.valid}, 32'd0);
      cycle();
      #2;
      check("t4_drop1",    {31'd0, ifc.valid}, 32'd0);
      repeat (8) cycle();
      check("t4_first_pop", first_pop, BYP ? 32'd6 : 32'd7);

      // ---- redirect coincident with a response and a would-be pop ----
      lat = 1;
      do_reset();
      repeat (4) cycle();
      check("t5_pre_pops", pops, BYP ? 32'd3 : 32'd2);
      ifc.redirect      = 1'b1;
      ifc.redirect_addr = 32'h0000_0200;
      #2;
      check("t5_valid",     {31'd0, ifc.valid}, 32'd0);
      check("t5_inst",      ifc.inst, 32'h0000_0013);
      check("t5_req_valid", {31'd0, ifc.ibus_req_valid}, 32'd0);
      exp_addr  = 32'h200;
      first_pop = -1;
      cycle();
      ifc.redirect = 1'b0;
      #2;
      check("t5_req_addr", ifc.ibus_req_addr, 32'h200);
      check("t5_valid_after", {31'd0, ifc.valid}, 32'd0);
      repeat (6) cycle();
      check("t5_first_pop", first_pop, BYP ? 32'd6 : 32'd7);

      // ---- single manual response into an empty queue (bypass timing) ----
      do_reset();
      bus_auto          = 1'b0;
      mon_en            = 1'b0;
      ifc.redirect      = 1'b1;
      ifc.redirect_addr = 32'h0000_0008;
      cycle();
      ifc.redirect = 1'b0;
      #2;
      check("t6_req_addr", ifc.ibus_req_addr, 32'h8);
      cycle();
      ifc.ibus_req_ready = 1'b0;
      ifc.ibus_rsp_valid = 1'b1;
      ifc.ibus_rsp_data  = 32'h0050_0093;
      #2;
      check("t6_same_valid", {31'd0, ifc.valid}, BYP ? 32'd1 : 32'd0);
      check("t6_same_inst",  ifc.inst, BYP ? 32'h0050_0093 : 32'h0000_0013);
      check("t6_same_addr",  ifc.instaddr, BYP ? 32'h8 : 32'h0);
      cycle();
      #2;
      check("t6_next_valid", {31'd0, ifc.valid}, BYP ? 32'd0 : 32'd1);
      check("t6_next_inst",  ifc.inst, BYP ? 32'h0000_0013 : 32'h0050_0093);
      check("t6_next_addr",  ifc.instaddr, BYP ? 32'h0 : 32'h8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
